// File: rtl/memory_access_bus.sv
// Memory-access pipeline stage: drives a req/ack bus with byte enables and replicated
// store data, checks alignment, extracts/extends load data and aborts hung transfers.
module memory_access_bus #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int REG_WIDTH   = 32,
   parameter int REGNO_WIDTH = 5,
   parameter int TIMEOUT     = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_stall,
   output logic                    o_mem_stall,
   output logic                    o_addr_error,
   output logic                    o_bus_error,
   input  logic [REGNO_WIDTH-1:0]  i_rd_no,
   input  logic [REG_WIDTH-1:0]    i_alu_result,
   input  logic [1:0]              i_lsu_op,
   input  logic                    i_lsu_lns,
   input  logic                    i_lsu_ext,
   input  logic [31:0]             i_mem_data,
   output logic [ADDR_WIDTH-1:0]   o_bus_addr,
   output logic [DATA_WIDTH-1:0]   o_bus_wdata,
   output logic [DATA_WIDTH/8-1:0] o_bus_be,
   output logic                    o_bus_rnw,
   output logic                    o_bus_req,
   input  logic                    i_bus_ack,
   input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
   input  logic                    i_bus_err,
   output logic [REGNO_WIDTH-1:0]  o_rd_no,
   output logic [REG_WIDTH-1:0]    o_rd_val
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(LANES);
   localparam int CW    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [2:0] {SEL_ALU, SEL_BU, SEL_BS, SEL_HU, SEL_HS, SEL_WU, SEL_WS} sel_t;

   state_t                 state_reg, state_next;
   sel_t                   sel_reg, sel_next;
   logic                   accept, is_mem, misaligned, issue, ack_done, abort;
   logic [CW-1:0]          count_reg, count_next;
   logic [OFS-1:0]         offset_reg;
   logic [REG_WIDTH-1:0]   alu_reg;
   logic [31:0]            load_reg;
   logic [DATA_WIDTH-1:0]  wdata_next;
   logic [LANES-1:0]       be_next;

   always_comb begin
      accept     = (state_reg == IDLE) && !i_stall;
      is_mem     = (i_lsu_op != 2'b00);
      misaligned = ((i_lsu_op == 2'b10) && i_alu_result[0]) ||
                   ((i_lsu_op == 2'b11) && (i_alu_result[1:0] != 2'b00));
      issue      = accept && is_mem && !misaligned;
      ack_done   = (state_reg == BUSY) && i_bus_ack;
      count_next = count_reg + 1'b1;
      // A coincident ack takes priority over the watchdog.
      abort      = (state_reg == BUSY) && !i_bus_ack && (TIMEOUT != 0) &&
                   (count_next == CW'(TIMEOUT));

      state_next = state_reg;
      if (issue)
         state_next = BUSY;
      else if (ack_done || abort)
         state_next = IDLE;

      sel_next = SEL_ALU;
      if (i_lsu_lns) begin
         case (i_lsu_op)
            2'b01:   sel_next = i_lsu_ext ? SEL_BS : SEL_BU;
            2'b10:   sel_next = i_lsu_ext ? SEL_HS : SEL_HU;
            2'b11:   sel_next = i_lsu_ext ? SEL_WS : SEL_WU;
            default: sel_next = SEL_ALU;
         endcase
      end

      be_next    = '0;
      wdata_next = '0;
      case (i_lsu_op)
         2'b01: begin
            be_next    = LANES'(1) << i_alu_result[OFS-1:0];
            wdata_next = {LANES{i_mem_data[7:0]}};
         end
         2'b10: begin
            be_next    = LANES'(2'b11) << i_alu_result[OFS-1:0];
            wdata_next = {(LANES/2){i_mem_data[15:0]}};
         end
         2'b11: begin
            be_next    = LANES'(4'hF) << i_alu_result[OFS-1:0];
            wdata_next = {(LANES/4){i_mem_data}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_mem_stall  <= 1'b0;
         o_addr_error <= 1'b0;
         o_bus_error  <= 1'b0;
         o_bus_addr   <= '0;
         o_bus_wdata  <= '0;
         o_bus_be     <= '0;
         o_bus_rnw    <= 1'b0;
         o_bus_req    <= 1'b0;
         o_rd_no      <= '0;
         alu_reg      <= '0;
         sel_reg      <= SEL_ALU;
         offset_reg   <= '0;
         count_reg    <= '0;
         load_reg     <= '0;
      end else begin
         o_mem_stall  <= (state_next == BUSY);
         o_addr_error <= 1'b0;
         o_bus_error  <= 1'b0;
         if (accept) begin
            o_rd_no    <= misaligned ? '0 : i_rd_no;
            o_addr_error <= misaligned;
            alu_reg    <= i_alu_result;
            sel_reg    <= sel_next;
            offset_reg <= i_alu_result[OFS-1:0];
            count_reg  <= '0;
            if (issue) begin
               o_bus_addr  <= i_alu_result[ADDR_WIDTH-1:0];
               o_bus_rnw   <= i_lsu_lns;
               o_bus_req   <= 1'b1;
               o_bus_be    <= be_next;
               o_bus_wdata <= wdata_next;
            end
         end else if (state_reg == BUSY) begin
            count_reg <= count_next;
            if (ack_done) begin
               o_bus_req <= 1'b0;
               load_reg  <= 32'(i_bus_rdata >> {offset_reg, 3'b000});
               if (i_bus_err) begin
                  o_bus_error <= 1'b1;
                  o_rd_no     <= '0;
               end
            end else if (abort) begin
               o_bus_req   <= 1'b0;
               o_bus_error <= 1'b1;
               o_rd_no     <= '0;
            end
         end
      end
   end

   always_comb begin
      case (sel_reg)
         SEL_BU:  o_rd_val = REG_WIDTH'(load_reg[7:0]);
         SEL_BS:  o_rd_val = REG_WIDTH'($signed(load_reg[7:0]));
         SEL_HU:  o_rd_val = REG_WIDTH'(load_reg[15:0]);
         SEL_HS:  o_rd_val = REG_WIDTH'($signed(load_reg[15:0]));
         SEL_WU:  o_rd_val = REG_WIDTH'(load_reg);
         SEL_WS:  o_rd_val = REG_WIDTH'($signed(load_reg));
         default: o_rd_val = alu_reg;
      endcase
   end
endmodule
